// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader and its skid buffer.
package fifo_reader_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-read and output-stream signals of the FIFO reader.
// master: the reader itself; slave: the FIFO plus the downstream consumer.
interface fifo_reader_if #(
    parameter type DATA_ITEM_TYPE = logic
);
    DATA_ITEM_TYPE fifo_head;
    logic          fifo_empty;
    logic          fifo_rd_rst_busy;
    logic          fifo_pop;
    DATA_ITEM_TYPE out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  fifo_head, fifo_empty, fifo_rd_rst_busy, out_ready,
        output fifo_pop, out_data, out_valid
    );

    modport slave (
        output fifo_head, fifo_empty, fifo_rd_rst_busy, out_ready,
        input  fifo_pop, out_data, out_valid
    );
endinterface

// File: rtl/skid_buf_m.sv
// Two-entry skid buffer, valid/ready on both sides. in_ready and the output
// side come straight from registers, so no combinational path crosses it.
module skid_buf_m
    import fifo_reader_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic
) (
    input  logic          clk,
    input  logic          rst,
    input  DATA_ITEM_TYPE in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output DATA_ITEM_TYPE out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    buf_state_e    state_q;
    DATA_ITEM_TYPE main_q;
    DATA_ITEM_TYPE skid_q;

    // Occupancy FSM: main holds the presented item, skid catches one extra.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        skid_q  <= in_data;
                        state_q <= TWO;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (out_ready) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/fifo_reader_m.sv
// Consumer-side adapter for the FWFT FIFO: gates pops into a skid buffer and
// presents a registered valid/ready stream.
// Optional: define FIFO_READER_CNT_EN to add the item_cnt delivered counter.
module fifo_reader_m
    import fifo_reader_pkg::*;
#(
    parameter type         DATA_ITEM_TYPE = logic,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fifo_reader_if.master     bus,
    output logic              idle
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_W-1:0]  item_cnt
`endif
);

    if (CNT_W == 0) begin : g_cnt_w_check
        $error("fifo_reader_m: CNT_W must be nonzero");
    end

    logic buf_in_ready;

    // Pop only from registered state and FIFO flags; rst term keeps pop low
    // while the buffer is held in reset.
    always_comb begin
        bus.fifo_pop = rst && enable && !bus.fifo_empty && !bus.fifo_rd_rst_busy
                       && buf_in_ready;
    end

    skid_buf_m #(
        .DATA_ITEM_TYPE (DATA_ITEM_TYPE)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.fifo_head),
        .in_valid  (bus.fifo_pop),
        .in_ready  (buf_in_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    // Nothing buffered and nothing left in the FIFO.
    always_comb begin
        idle = !bus.out_valid && bus.fifo_empty;
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count every accepted output item, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign item_cnt = cnt_q;
`endif

endmodule

// File: doc/fifo_reader_m.md
# fifo_reader_m

Consumer-side adapter for the single-clock first-word-fall-through (FWFT) FIFO. It drains the FIFO's head/empty/pop interface and presents the data as a registered valid/ready stream to downstream logic. A two-entry skid buffer sustains one item per clock while keeping `fifo_pop` and `out_data` free of combinational paths from `out_ready`. It sits directly after `fifo_sc_m`, in every datapath where a FIFO feeds a backpressuring consumer.

## Interface
- `DATA_ITEM_TYPE`, default `logic`: item type, identical to the FIFO's item type.
- `CNT_W`, default 16: width of the delivered-item counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `enable`  in  1  permits popping from the FIFO; already-buffered items drain regardless.
- `fifo_head`  in  `$bits(DATA_ITEM_TYPE)`  FIFO FWFT head item.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_rst_busy`  in  1  FIFO read side still in reset; no pop while high.
- `fifo_pop`  out  1  FIFO pop strobe.
- `out_data`  out  `$bits(DATA_ITEM_TYPE)`  stream data (registered).
- `out_valid`  out  1  stream valid (registered).
- `out_ready`  in  1  downstream ready.
- `idle`  out  1  high when the buffer is empty and `fifo_empty` is high.
- `item_cnt`  out  `CNT_W`  items delivered. Present only with `FIFO_READER_CNT_EN`.

## Operation
- Buffer states: `EMPTY` (0 items), `ONE` (main register valid), `TWO` (main and skid registers valid).
- `fifo_pop = rst && enable && !fifo_empty && !fifo_rd_rst_busy && (state != TWO)`. It depends only on registered state and FIFO flags, never on `out_ready`.
- Transitions. Here, pop means `fifo_pop` is high and rdy means `out_ready` is high.
  - `EMPTY`: on pop, load main from `fifo_head` and go to `ONE`. Otherwise stay.
  - `ONE`: on pop and rdy, load main from `fifo_head` and stay in `ONE`.
  - `ONE`: on pop without rdy, load skid from `fifo_head` and go to `TWO`.
  - `ONE`: on rdy without pop, go to `EMPTY`. On neither, stay.
  - `TWO`: on rdy, move skid into main and go to `ONE`. Otherwise stay; no pop occurs in `TWO`.
- `out_valid` is high exactly when state is not `EMPTY`. `out_data` is the main register.
- Item order is strict FIFO order. There is no duplication and no loss.
- Deasserting `enable` stops new pops only. The buffer keeps draining to `out_ready`.
- A pop never occurs while `fifo_empty` is high, so the FIFO cannot underflow.
- `item_cnt` increments on every `out_valid && out_ready` and wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state `EMPTY`, `out_valid` 0, `out_data` '0, skid register '0, `item_cnt` 0. `fifo_pop` is 0 while `rst` is low. `idle` equals `fifo_empty`.
- Latency: an item popped at edge N is on `out_data` with `out_valid` high after edge N (visible in cycle N+1).
- Throughput: one item per clock while the FIFO is non-empty and `out_ready` is held high.
- Stream rule: while `out_valid && !out_ready`, both `out_data` and `out_valid` hold unchanged.
- Backpressure: at most one extra pop after `out_ready` falls (it fills the skid register). After that, `fifo_pop` stays low.
- Reset mid-operation: buffered items are discarded immediately, without waiting for a clock edge. After release, the first pop may occur in the first cycle where the pop conditions hold.
- `fifo_rd_rst_busy` high with `fifo_empty` low: no pop; the buffer drains normally.

## Configuration
- `FIFO_READER_CNT_EN` defined: the `item_cnt` port and its counter are compiled in.
- `FIFO_READER_CNT_EN` not defined: the port and counter are absent, and all other behaviour is identical.

## Structure
- `fifo_reader_pkg`: buffer state enum typedef (`EMPTY`, `ONE`, `TWO`) and the default `CNT_W` constant.
- One natural sub-module, `skid_buf_m`: the 2-entry buffer with its state machine, valid/ready on both sides. It is reusable elsewhere. `fifo_reader_m` adds the pop gating, `idle` and the counter.

## Test plan
- Reset release with 4 items already in the FIFO and `out_ready` held at 1: items appear on consecutive cycles in order. `fifo_pop` is high for exactly 4 cycles, and `item_cnt` ends at 4.
- FIFO holds 5 items, `out_ready` is held at 0: exactly 2 pops occur, `out_data` holds item 0 stable, and the state stays `TWO`. Then `out_ready` goes to 1: items 1–4 follow without loss.
- `out_ready` toggles 1010… with a random FIFO fill of 100 items: the output sequence equals the input sequence, and `fifo_pop` is never high while `fifo_empty` is high.
- `enable` drops while in `TWO`: no further pops, both buffered items are delivered, and `idle` stays low because the FIFO is non-empty.
- `fifo_rd_rst_busy` held high for 10 cycles with the FIFO non-empty: `fifo_pop` stays 0 throughout. Normal draining starts the cycle after it falls.
- `rst` asserted while in `TWO`: `out_valid` goes to 0 immediately. With `CNT_W`=4, delivering 17 items gives `item_cnt` = 1.
